// File: rtl/block_match_engine_pkg.sv
// Shared block-matching definitions: geometry, derived constants, FSM states
// and the read-address helpers used by the engine.
package block_match_engine_pkg;

  localparam int RD_PORT_W    = 8;    // pixels per RAM word
  localparam int THIRD_W      = 240;  // block-buffer line width in pixels
  localparam int CENTER_W     = 304;  // search-buffer line width in pixels
  localparam int BLOCK_WIDTH  = 16;
  localparam int BLOCK_HEIGHT = 16;
  localparam int SEARCH_BLK_W = 64;
  localparam int SEARCH_BLK_H = 32;
  localparam int PIX_W        = 8;
  localparam int RD_LATENCY   = 2;    // RAM read latency in cycles

  localparam int WORD_W             = RD_PORT_W * PIX_W;                 // 64
  localparam int BLK_WORDS_PER_ROW  = THIRD_W / RD_PORT_W;               // 30
  localparam int SRCH_WORDS_PER_ROW = CENTER_W / RD_PORT_W;              // 38
  localparam int NUM_CAND           = SEARCH_BLK_W - BLOCK_WIDTH + 1;    // 49
  localparam int ROW_OFFSET         = (SEARCH_BLK_H - BLOCK_HEIGHT) / 2; // 8
  localparam int SRCH_WORDS         = SEARCH_BLK_W / RD_PORT_W;          // 8
  localparam int BLK_WORDS          = BLOCK_WIDTH / RD_PORT_W;           // 2
  localparam int READ_CYCLES        = BLOCK_HEIGHT * SRCH_WORDS;         // 128

  localparam int ADDR_W    = 16;
  localparam int SAD_W     = 16;
  localparam int DISP_W    = 6;
  localparam int ROW_SAD_W = $clog2(BLOCK_WIDTH * ((1 << PIX_W) - 1) + 1); // 12

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_MIN   = 3'd3,
    ST_OUT   = 3'd4
  } bm_state_e;

  // Search word for read step k: row k/8 of the block maps to window row k/8+8.
  function automatic logic [ADDR_W-1:0] srch_word_addr(input logic [ADDR_W-1:0] base,
                                                       input logic [6:0] k);
    logic [ADDR_W-1:0] row;
    row = ADDR_W'(k[6:3]) + ADDR_W'(ROW_OFFSET);
    return base + row * ADDR_W'(SRCH_WORDS_PER_ROW) + ADDR_W'(k[2:0]);
  endfunction

  // Block word for read step k: only two words per row exist, so w&1 repeats them.
  function automatic logic [ADDR_W-1:0] blk_word_addr(input logic [ADDR_W-1:0] base,
                                                      input logic [6:0] k);
    return base + ADDR_W'(k[6:3]) * ADDR_W'(BLK_WORDS_PER_ROW) + ADDR_W'(k[0]);
  endfunction

endpackage

// File: rtl/block_match_engine_if.sv
// Controller / RAM / result bundle of the block-matching engine.
//
// Start handshake: the controller raises bm_start and holds it until bm_done
// falls. The engine samples bm_start only while idle (bm_done high); the job
// parameters blk_addr, srch_addr and blk_index are latched on that edge and
// may change freely afterwards. result_valid is a one-cycle strobe; the
// result_* fields stay stable until the next strobe. The read ports have a
// fixed latency of RD_LATENCY cycles and no back-pressure.
interface block_match_engine_if;
  import block_match_engine_pkg::*;

  logic              bm_start;
  logic [ADDR_W-1:0] blk_addr;
  logic [ADDR_W-1:0] srch_addr;
  logic [15:0]       blk_index;
  logic              bm_done;

  logic [ADDR_W-1:0] blk_rd_addr;
  logic [WORD_W-1:0] blk_rd_data;
  logic [ADDR_W-1:0] srch_rd_addr;
  logic [WORD_W-1:0] srch_rd_data;

  logic              result_valid;
  logic [15:0]       result_index;
  logic [DISP_W-1:0] result_disp;
  logic [SAD_W-1:0]  result_sad;

  modport master (
    output bm_start, blk_addr, srch_addr, blk_index, blk_rd_data, srch_rd_data,
    input  bm_done, blk_rd_addr, srch_rd_addr,
    input  result_valid, result_index, result_disp, result_sad
  );

  modport slave (
    input  bm_start, blk_addr, srch_addr, blk_index, blk_rd_data, srch_rd_data,
    output bm_done, blk_rd_addr, srch_rd_addr,
    output result_valid, result_index, result_disp, result_sad
  );

endinterface

// File: rtl/block_match_engine_row_sad.sv
// Combinational sum of absolute differences over one 16-pixel row for a
// single disparity candidate.
module bm_row_sad
  import block_match_engine_pkg::*;
(
  input  logic [BLOCK_WIDTH*PIX_W-1:0] blk_pix_i,
  input  logic [BLOCK_WIDTH*PIX_W-1:0] srch_pix_i,
  output logic [ROW_SAD_W-1:0]         sad_o
);

  logic [PIX_W-1:0] a_pix;
  logic [PIX_W-1:0] b_pix;

  // Accumulate |a-b| pixel by pixel; 16*255 fits in ROW_SAD_W bits.
  always_comb begin
    sad_o = '0;
    a_pix = '0;
    b_pix = '0;
    for (int x = 0; x < BLOCK_WIDTH; x++) begin
      a_pix = blk_pix_i[x*PIX_W +: PIX_W];
      b_pix = srch_pix_i[x*PIX_W +: PIX_W];
      sad_o = sad_o + ROW_SAD_W'((a_pix > b_pix) ? (a_pix - b_pix) : (b_pix - a_pix));
    end
  end

endmodule

// File: rtl/block_match_engine.sv
// Block-matching engine: streams one 16x16 block and its 64-pixel-wide search
// band row by row, accumulates SAD for 49 horizontal disparities in parallel,
// then scans the accumulators for the lowest SAD (lowest d wins ties).
module block_match_engine
  import block_match_engine_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  block_match_engine_if.slave  bm_if,
  output bm_state_e            dbg_state_o
);

  bm_state_e state_q, state_d;
  logic [6:0] cnt_q, cnt_d;

  logic [ADDR_W-1:0] blk_base_q, srch_base_q;
  logic [15:0]       index_q;
  logic              start_accept;

  logic [RD_LATENCY-1:0] vld_q;
  logic [2:0]            wsel_q [RD_LATENCY];
  logic                  cap_vld;
  logic [2:0]            cap_w;

  logic [SEARCH_BLK_W*PIX_W-1:0] srch_row_q;
  logic [BLK_WORDS*WORD_W-1:0]   blk_row_q;
  logic                          row_done_q;

  logic [ROW_SAD_W-1:0] row_sad [NUM_CAND];
  logic [SAD_W-1:0]     acc_q   [NUM_CAND];

  logic [SAD_W-1:0]  cand_sad, best_sad_q, best_sad_d;
  logic [DISP_W-1:0] best_disp_q, best_disp_d;
  logic              take_cand;

  logic [15:0]       result_index_q;
  logic [DISP_W-1:0] result_disp_q;
  logic [SAD_W-1:0]  result_sad_q;

  assign start_accept = (state_q == ST_IDLE) && bm_if.bm_start;
  assign cap_vld      = vld_q[RD_LATENCY-1];
  assign cap_w        = wsel_q[RD_LATENCY-1];

  // FSM state register and phase counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; the counter restarts at every state change.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bm_if.bm_start)                    state_d = ST_READ;
      ST_READ:  if (cnt_q == 7'(READ_CYCLES - 1))      state_d = ST_DRAIN;
      ST_DRAIN: if (cnt_q == 7'(RD_LATENCY))           state_d = ST_MIN;
      ST_MIN:   if (cnt_q == 7'(NUM_CAND - 1))         state_d = ST_OUT;
      ST_OUT:                                          state_d = ST_IDLE;
      default:                                         state_d = ST_IDLE;
    endcase
    cnt_d = ((state_d != state_q) || (state_q == ST_IDLE)) ? 7'd0 : cnt_q + 7'd1;
  end

  // FSM outputs: status, read addresses (zero when not reading), results.
  always_comb begin
    bm_if.bm_done      = (state_q == ST_IDLE);
    bm_if.result_valid = (state_q == ST_OUT);
    bm_if.blk_rd_addr  = '0;
    bm_if.srch_rd_addr = '0;
    if (state_q == ST_READ) begin
      bm_if.blk_rd_addr  = blk_word_addr(blk_base_q, cnt_q);
      bm_if.srch_rd_addr = srch_word_addr(srch_base_q, cnt_q);
    end
    bm_if.result_index = result_index_q;
    bm_if.result_disp  = result_disp_q;
    bm_if.result_sad   = result_sad_q;
    dbg_state_o        = state_q;
  end

  // Latch job parameters when a start is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_base_q  <= '0;
      srch_base_q <= '0;
      index_q     <= '0;
    end else if (start_accept) begin
      blk_base_q  <= bm_if.blk_addr;
      srch_base_q <= bm_if.srch_addr;
      index_q     <= bm_if.blk_index;
    end
  end

  // Track in-flight reads so each returned word lands in its slot; reset
  // empties the pipe, which discards data still coming back from the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) wsel_q[i] <= '0;
    end else begin
      vld_q[0]  <= (state_q == ST_READ);
      wsel_q[0] <= cnt_q[2:0];
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        wsel_q[i] <= wsel_q[i-1];
      end
    end
  end

  // Capture returned words into the row registers; flag the row complete
  // when its last search word arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      srch_row_q <= '0;
      blk_row_q  <= '0;
      row_done_q <= 1'b0;
    end else begin
      row_done_q <= cap_vld && (cap_w == 3'(SRCH_WORDS - 1));
      if (cap_vld) begin
        srch_row_q[int'(cap_w)*WORD_W +: WORD_W]    <= bm_if.srch_rd_data;
        blk_row_q[int'(cap_w[0])*WORD_W +: WORD_W]  <= bm_if.blk_rd_data;
      end
    end
  end

  for (genvar d = 0; d < NUM_CAND; d++) begin : g_cand
    bm_row_sad u_row_sad (
      .blk_pix_i  (blk_row_q),
      .srch_pix_i (srch_row_q[d*PIX_W +: BLOCK_WIDTH*PIX_W]),
      .sad_o      (row_sad[d])
    );
  end

  // Per-candidate accumulators: cleared on a new job, bumped once per row.
  always_ff @(posedge clk) begin
    if (reset || start_accept) begin
      for (int d = 0; d < NUM_CAND; d++) acc_q[d] <= '0;
    end else if (row_done_q) begin
      for (int d = 0; d < NUM_CAND; d++) acc_q[d] <= acc_q[d] + SAD_W'(row_sad[d]);
    end
  end

  // Minimum scan step: candidate d=cnt replaces the best only if strictly lower.
  always_comb begin
    cand_sad = '0;
    if (cnt_q < 7'(NUM_CAND)) cand_sad = acc_q[cnt_q[5:0]];
    take_cand   = (cnt_q == 7'd0) || (cand_sad < best_sad_q);
    best_sad_d  = take_cand ? cand_sad   : best_sad_q;
    best_disp_d = take_cand ? cnt_q[5:0] : best_disp_q;
  end

  // Running minimum during MIN; publish the result as the scan finishes.
  always_ff @(posedge clk) begin
    if (reset) begin
      best_sad_q     <= '0;
      best_disp_q    <= '0;
      result_index_q <= '0;
      result_disp_q  <= '0;
      result_sad_q   <= '0;
    end else if (state_q == ST_MIN) begin
      best_sad_q  <= best_sad_d;
      best_disp_q <= best_disp_d;
      if (cnt_q == 7'(NUM_CAND - 1)) begin
        result_index_q <= index_q;
        result_disp_q  <= best_disp_d;
        result_sad_q   <= best_sad_d;
      end
    end
  end

endmodule

// File: tb/tb_block_match_engine.sv
// Directed bench for block_match_engine: builds block/search images, lays
// them out in two RAM models and checks result, timing and addressing.
module tb_block_match_engine;
  import block_match_engine_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  bm_state_e dbg_state;

  block_match_engine_if bm_if ();

  block_match_engine dut (
    .clk         (clk),
    .reset       (reset),
    .bm_if       (bm_if),
    .dbg_state_o (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [63:0] blk_mem  [65536];
  logic [63:0] srch_mem [65536];
  logic [15:0] blk_a1, srch_a1;

  // Two-cycle read RAMs: address registered, then data registered.
  always @(posedge clk) begin
    blk_a1             <= bm_if.blk_rd_addr;
    srch_a1            <= bm_if.srch_rd_addr;
    bm_if.blk_rd_data  <= blk_mem[blk_a1];
    bm_if.srch_rd_data <= srch_mem[srch_a1];
  end

  logic [7:0] b_img [16][16];
  logic [7:0] s_img [32][64];

  logic [5:0]  exp_disp;
  logic [15:0] exp_sad;

  int          obs_lat, obs_valid_cnt;
  logic        obs_done0, obs_done_after;
  logic [15:0] obs_srch0, obs_blk0, obs_srch9, obs_blk9;
  logic [15:0] obs_index, obs_sad, obs_sad_after;
  logic [5:0]  obs_disp, obs_disp_after;

  task automatic load_images(input logic [15:0] ba, input logic [15:0] sa);
    logic [63:0] word;
    for (int r = 0; r < 16; r++)
      for (int j = 0; j < 2; j++) begin
        for (int p = 0; p < 8; p++) word[p*8 +: 8] = b_img[r][j*8+p];
        blk_mem[ba + 16'(r*30 + j)] = word;
      end
    for (int r = 0; r < 32; r++)
      for (int w = 0; w < 8; w++) begin
        for (int p = 0; p < 8; p++) word[p*8 +: 8] = s_img[r][w*8+p];
        srch_mem[sa + 16'(r*38 + w)] = word;
      end
  endtask

  task automatic fill_flat(input logic [7:0] bv, input logic [7:0] sv);
    for (int r = 0; r < 16; r++) for (int x = 0; x < 16; x++) b_img[r][x] = bv;
    for (int r = 0; r < 32; r++) for (int x = 0; x < 64; x++) s_img[r][x] = sv;
  endtask

  task automatic fill_random();
    for (int r = 0; r < 16; r++) for (int x = 0; x < 16; x++) b_img[r][x] = 8'($urandom_range(0, 255));
    for (int r = 0; r < 32; r++) for (int x = 0; x < 64; x++) s_img[r][x] = 8'($urandom_range(0, 255));
  endtask

  // Reference: full SAD for every disparity, strict-less keeps lowest d.
  task automatic calc_expected();
    int s, best, a, b;
    best = 0;
    exp_disp = 6'd0;
    for (int d = 0; d < 49; d++) begin
      s = 0;
      for (int r = 0; r < 16; r++)
        for (int x = 0; x < 16; x++) begin
          a = int'(b_img[r][x]);
          b = int'(s_img[r+8][x+d]);
          s += (a > b) ? (a - b) : (b - a);
        end
      if (d == 0 || s < best) begin
        best = s;
        exp_disp = 6'(d);
      end
    end
    exp_sad = 16'(best);
  endtask

  // Driver: start a job, watch 200 cycles from READ entry (cycle 0).
  // reassert_at >= 0 raises a second start with different fields mid-job.
  task automatic run_job(input logic [15:0] ba, input logic [15:0] sa,
                         input logic [15:0] idx, input int reassert_at);
    obs_lat = -1;
    obs_valid_cnt = 0;
    obs_done_after = 1'b0;
    @(negedge clk);
    bm_if.blk_addr  = ba;
    bm_if.srch_addr = sa;
    bm_if.blk_index = idx;
    bm_if.bm_start  = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n == 0) begin
        obs_done0 = bm_if.bm_done;
        obs_srch0 = bm_if.srch_rd_addr;
        obs_blk0  = bm_if.blk_rd_addr;
        bm_if.bm_start = 1'b0;
      end
      if (n == 9) begin
        obs_srch9 = bm_if.srch_rd_addr;
        obs_blk9  = bm_if.blk_rd_addr;
      end
      if (n == reassert_at) begin
        bm_if.bm_start  = 1'b1;
        bm_if.blk_index = ~idx;
        bm_if.blk_addr  = ba + 16'h0100;
        bm_if.srch_addr = sa + 16'h0100;
      end
      if (reassert_at >= 0 && n == reassert_at + 5) begin
        bm_if.bm_start  = 1'b0;
        bm_if.blk_index = idx;
        bm_if.blk_addr  = ba;
        bm_if.srch_addr = sa;
      end
      if (obs_lat >= 0 && n == obs_lat + 1) begin
        obs_done_after = bm_if.bm_done;
        obs_sad_after  = bm_if.result_sad;
        obs_disp_after = bm_if.result_disp;
      end
      if (bm_if.result_valid === 1'b1) begin
        obs_valid_cnt++;
        if (obs_lat < 0) begin
          obs_lat   = n;
          obs_index = bm_if.result_index;
          obs_disp  = bm_if.result_disp;
          obs_sad   = bm_if.result_sad;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bm_if.bm_done !== 1'b1) begin failures++; $display("FAIL reset_done: got %0d expected 1", bm_if.bm_done); end
    checks++; if (bm_if.result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0d expected 0", bm_if.result_valid); end
    checks++; if (bm_if.result_index !== 16'd0) begin failures++; $display("FAIL reset_index: got %0h expected 0", bm_if.result_index); end
    checks++; if (bm_if.result_disp !== 6'd0) begin failures++; $display("FAIL reset_disp: got %0d expected 0", bm_if.result_disp); end
    checks++; if (bm_if.result_sad !== 16'd0) begin failures++; $display("FAIL reset_sad: got %0d expected 0", bm_if.result_sad); end
    checks++; if (bm_if.srch_rd_addr !== 16'd0 || bm_if.blk_rd_addr !== 16'd0) begin failures++; $display("FAIL reset_addr: got %0h/%0h expected 0/0", bm_if.srch_rd_addr, bm_if.blk_rd_addr); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    reset = 1'b0;
  endtask

  task automatic test_flat();
    fill_flat(8'h40, 8'h40);
    load_images(16'h0100, 16'h2000);
    run_job(16'h0100, 16'h2000, 16'h0011, -1);
    checks++; if (obs_done0 !== 1'b0) begin failures++; $display("FAIL flat_done_low: got %0d expected 0", obs_done0); end
    checks++; if (obs_srch0 !== 16'h2130) begin failures++; $display("FAIL flat_srch_addr0: got %0h expected 2130", obs_srch0); end
    checks++; if (obs_blk0 !== 16'h0100) begin failures++; $display("FAIL flat_blk_addr0: got %0h expected 0100", obs_blk0); end
    checks++; if (obs_srch9 !== 16'h2157) begin failures++; $display("FAIL flat_srch_addr9: got %0h expected 2157", obs_srch9); end
    checks++; if (obs_blk9 !== 16'h011F) begin failures++; $display("FAIL flat_blk_addr9: got %0h expected 011f", obs_blk9); end
    checks++; if (obs_lat !== 180) begin failures++; $display("FAIL flat_latency: got %0d expected 180", obs_lat); end
    checks++; if (obs_valid_cnt !== 1) begin failures++; $display("FAIL flat_valid_count: got %0d expected 1", obs_valid_cnt); end
    checks++; if (obs_disp !== 6'd0) begin failures++; $display("FAIL flat_disp: got %0d expected 0", obs_disp); end
    checks++; if (obs_sad !== 16'd0) begin failures++; $display("FAIL flat_sad: got %0d expected 0", obs_sad); end
    checks++; if (obs_index !== 16'h0011) begin failures++; $display("FAIL flat_index: got %0h expected 0011", obs_index); end
    checks++; if (obs_done_after !== 1'b1) begin failures++; $display("FAIL flat_done_back: got %0d expected 1", obs_done_after); end
  endtask

  task automatic test_shift17();
    fill_random();
    for (int r = 0; r < 16; r++) for (int x = 0; x < 16; x++) s_img[r+8][x+17] = b_img[r][x];
    load_images(16'h1234, 16'h4000);
    run_job(16'h1234, 16'h4000, 16'hBEEF, -1);
    checks++; if (obs_disp !== 6'd17) begin failures++; $display("FAIL shift_disp: got %0d expected 17", obs_disp); end
    checks++; if (obs_sad !== 16'd0) begin failures++; $display("FAIL shift_sad: got %0d expected 0", obs_sad); end
    checks++; if (obs_index !== 16'hBEEF) begin failures++; $display("FAIL shift_index: got %0h expected beef", obs_index); end
    checks++; if (obs_lat !== 180) begin failures++; $display("FAIL shift_latency: got %0d expected 180", obs_lat); end
    checks++; if (obs_disp_after !== 6'd17 || obs_sad_after !== 16'd0) begin failures++; $display("FAIL shift_hold: got %0d/%0d expected 17/0", obs_disp_after, obs_sad_after); end
  endtask

  task automatic test_tie();
    fill_flat(8'h10, 8'h80);
    for (int r = 8; r < 24; r++)
      for (int x = 0; x < 16; x++) begin
        s_img[r][5+x]  = 8'h11;
        s_img[r][30+x] = 8'h0F;
      end
    load_images(16'h3000, 16'h5000);
    run_job(16'h3000, 16'h5000, 16'h0005, -1);
    checks++; if (obs_disp !== 6'd5) begin failures++; $display("FAIL tie_disp: got %0d expected 5", obs_disp); end
    checks++; if (obs_sad !== 16'd256) begin failures++; $display("FAIL tie_sad: got %0d expected 256", obs_sad); end
  endtask

  task automatic test_max_sad();
    fill_flat(8'hFF, 8'h00);
    load_images(16'h0200, 16'h6000);
    run_job(16'h0200, 16'h6000, 16'h00FF, -1);
    checks++; if (obs_sad !== 16'hFF00) begin failures++; $display("FAIL max_sad: got %0h expected ff00", obs_sad); end
    checks++; if (obs_disp !== 6'd0) begin failures++; $display("FAIL max_disp: got %0d expected 0", obs_disp); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 2; t++) begin
      fill_random();
      calc_expected();
      load_images(16'h0400 + 16'(t*16'h0400), 16'h7000);
      run_job(16'h0400 + 16'(t*16'h0400), 16'h7000, 16'(16'hA000 + t), -1);
      checks++; if (obs_disp !== exp_disp) begin failures++; $display("FAIL random_disp[%0d]: got %0d expected %0d", t, obs_disp, exp_disp); end
      checks++; if (obs_sad !== exp_sad) begin failures++; $display("FAIL random_sad[%0d]: got %0d expected %0d", t, obs_sad, exp_sad); end
    end
  endtask

  task automatic test_wrap_and_ignore();
    fill_random();
    calc_expected();
    load_images(16'hFFF0, 16'hFED0);
    run_job(16'hFFF0, 16'hFED0, 16'h1357, 20);
    checks++; if (obs_srch0 !== 16'h0000) begin failures++; $display("FAIL wrap_srch_addr0: got %0h expected 0000", obs_srch0); end
    checks++; if (obs_srch9 !== 16'h0027) begin failures++; $display("FAIL wrap_srch_addr9: got %0h expected 0027", obs_srch9); end
    checks++; if (obs_blk9 !== 16'h000F) begin failures++; $display("FAIL wrap_blk_addr9: got %0h expected 000f", obs_blk9); end
    checks++; if (obs_valid_cnt !== 1) begin failures++; $display("FAIL ignore_valid_count: got %0d expected 1", obs_valid_cnt); end
    checks++; if (obs_lat !== 180) begin failures++; $display("FAIL ignore_latency: got %0d expected 180", obs_lat); end
    checks++; if (obs_index !== 16'h1357) begin failures++; $display("FAIL ignore_index: got %0h expected 1357", obs_index); end
    checks++; if (obs_disp !== exp_disp || obs_sad !== exp_sad) begin failures++; $display("FAIL wrap_result: got %0d/%0d expected %0d/%0d", obs_disp, obs_sad, exp_disp, exp_sad); end
  endtask

  task automatic test_reset_mid_job();
    int vcount;
    vcount = 0;
    fill_random();
    calc_expected();
    load_images(16'h0800, 16'h9000);
    @(negedge clk);
    bm_if.blk_addr  = 16'h0800;
    bm_if.srch_addr = 16'h9000;
    bm_if.blk_index = 16'h2222;
    bm_if.bm_start  = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 250; n++) begin
      @(negedge clk);
      if (n == 0) bm_if.bm_start = 1'b0;
      if (bm_if.result_valid === 1'b1) vcount++;
      if (n == 51) begin
        checks++; if (bm_if.bm_done !== 1'b1) begin failures++; $display("FAIL abort_done: got %0d expected 1", bm_if.bm_done); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL abort_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        reset = 1'b0;
      end
      if (n == 50) reset = 1'b1;
    end
    checks++; if (vcount !== 0) begin failures++; $display("FAIL abort_no_result: got %0d expected 0", vcount); end
    run_job(16'h0800, 16'h9000, 16'h3333, -1);
    checks++; if (obs_lat !== 180) begin failures++; $display("FAIL after_abort_latency: got %0d expected 180", obs_lat); end
    checks++; if (obs_disp !== exp_disp || obs_sad !== exp_sad) begin failures++; $display("FAIL after_abort_result: got %0d/%0d expected %0d/%0d", obs_disp, obs_sad, exp_disp, exp_sad); end
    checks++; if (obs_index !== 16'h3333) begin failures++; $display("FAIL after_abort_index: got %0h expected 3333", obs_index); end
  endtask

  initial begin
    reset           = 1'b1;
    bm_if.bm_start  = 1'b0;
    bm_if.blk_addr  = '0;
    bm_if.srch_addr = '0;
    bm_if.blk_index = '0;
    for (int i = 0; i < 65536; i++) begin
      blk_mem[i]  = '0;
      srch_mem[i] = '0;
    end
    test_reset();
    test_flat();
    test_shift17();
    test_tie();
    test_max_sad();
    test_random();
    test_wrap_and_ignore();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/block_match_engine.md
BLOCK_MATCH_ENGINE -- requirements
Module: block_match_engine

Interface
REQ-001 Parameters: rd_port_w=8 (pixels per RAM word); third_w=240; center_w=304; block_width=16; block_height=16; search_blk_w=64; search_blk_h=32; pix_w=8; rd_latency=2 (RAM read latency, cycles).
REQ-002 clk in 1: single clock; all logic on its rising edge.
REQ-003 reset in 1: synchronous, active-high.
REQ-004 bm_start in 1: start request, held by the controller until bm_done falls.
REQ-005 blk_addr in 16: block-buffer word address of block row 0, word 0.
REQ-006 srch_addr in 16: search-buffer word address of search-window row 0, word 0.
REQ-007 blk_index in 16: tag echoed on the result.
REQ-008 bm_done out 1: high only while idle.
REQ-009 blk_rd_addr out 16 and blk_rd_data in 64: block RAM read port.
REQ-010 srch_rd_addr out 16 and srch_rd_data in 64: search RAM read port.
REQ-011 result_valid out 1: one-cycle result strobe.
REQ-012 result_index out 16, result_disp out 6, result_sad out 16: tag, best disparity, minimum SAD.

Function
REQ-013 Each word carries 8 pixels; pixel i occupies bits [8i+7:8i]; pixel 0 is leftmost.
REQ-014 Candidates d=0..48; SAD(d) = sum over r=0..15, x=0..15 of |B[r][x] - S[r+8][x+d]|, unsigned, 16-bit, no overflow possible (max 65280).
REQ-015 States: IDLE, READ, DRAIN, MIN, OUT; bm_done = (state==IDLE).
REQ-016 IDLE: bm_start high at an edge latches blk_addr, srch_addr and blk_index, clears all 49 accumulators and enters READ; bm_done is low the next cycle.
REQ-017 READ lasts exactly 128 cycles, k=0..127, row=k/8, w=k%8.
REQ-018 During READ, srch_rd_addr = srch_addr + (8+row)*38 + w, and blk_rd_addr = blk_addr + row*30 + (w&1).
REQ-019 All address sums are modulo 2^16; negative srch_addr wraps in two's complement.
REQ-020 Returned data is captured exactly rd_latency cycles after issue into a 64-pixel search row register and a 16-pixel block row register.
REQ-021 When a row's 8th search word is captured, all 49 accumulators add that row's SAD contribution in the following cycle.
REQ-022 DRAIN lasts rd_latency+1 cycles, then enters MIN.
REQ-023 MIN lasts 49 cycles and scans d=0..48 sequentially; a strict less-than compare keeps the lowest d on ties.
REQ-024 OUT lasts 1 cycle: result_valid=1 with result_index, result_disp and result_sad valid; the next state is IDLE.
REQ-025 result_* hold their values until the next OUT.
REQ-026 Start-to-result_valid latency is exactly 128+rd_latency+1+49 cycles after READ entry; READ entry is the cycle after the start-sampling edge.
REQ-027 bm_start is ignored outside IDLE.
REQ-028 bm_start still high in the cycle bm_done returns high starts a new job; the controller deasserts it before then.

Reset
REQ-029 Reset: state=IDLE, bm_done=1, result_valid=0, result_index=0, result_disp=0, result_sad=0, read addresses=0, accumulators cleared.
REQ-030 Reset mid-job aborts the job: no result_valid; returned read data is discarded; bm_done=1 the cycle after reset.

Structure
REQ-031 The state enum and derived constants (words per row 30/38, candidates 49, row offset 8) reside in the shared block-matching package.
REQ-032 One sub-module, bm_row_sad: a combinational 16-pixel SAD for one candidate, instantiated 49 times by generate.

Verification
REQ-033 Flat frames: all pixels 0x40 -> disp 0, sad 0; result_valid at READ entry +180 cycles.
REQ-034 Search rows equal block rows shifted by 17, random elsewhere -> disp 17, sad 0, result_index == blk_index.
REQ-035 Exact equal minima at d=5 and d=30 -> disp 5.
REQ-036 Block 0xFF, search 0x00 -> sad 65280 (0xFF00), disp 0.
REQ-037 srch_addr=0xFED0 -> first srch_rd_addr=0x0000; second start mid-job ignored.
REQ-038 Reset at READ k=50 -> no result_valid, bm_done=1 next cycle; the next job completes correctly.
